// File: rtl/tnoc_axi_adapter_pkg.sv
// Shared types and helpers for the AXI adapter virtual-channel allocation path.
package tnoc_axi_adapter_pkg;

    typedef struct packed {
        int unsigned virtual_channels;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

    typedef enum logic {
        IDLE,
        ALLOC
    } tnoc_vc_alloc_state;

    function automatic int unsigned vc_width(int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned outstanding_width(int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/tnoc_axi_vc_allocator_if.sv
// Request/grant/completion bundle between the AXI mux side and the VC allocator.
interface tnoc_axi_vc_allocator_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned VC_WIDTH = 1
);
    logic [CHANNELS-1:0] i_vc_available;
    logic                i_write_request;
    logic                i_write_accept;
    logic                i_write_tail;
    logic                o_write_grant;
    logic [VC_WIDTH-1:0] o_write_vc;
    logic                i_read_request;
    logic                i_read_accept;
    logic                i_read_tail;
    logic                o_read_grant;
    logic [VC_WIDTH-1:0] o_read_vc;
    logic                i_done_valid;
    logic [VC_WIDTH-1:0] i_done_vc;

    modport slave (
        input  i_vc_available,
        input  i_write_request, i_write_accept, i_write_tail,
        output o_write_grant, o_write_vc,
        input  i_read_request, i_read_accept, i_read_tail,
        output o_read_grant, o_read_vc,
        input  i_done_valid, i_done_vc
    );

    modport master (
        output i_vc_available,
        output i_write_request, i_write_accept, i_write_tail,
        input  o_write_grant, o_write_vc,
        output i_read_request, i_read_accept, i_read_tail,
        input  o_read_grant, o_read_vc,
        output i_done_valid, i_done_vc
    );
endinterface

// File: rtl/tnoc_vc_rr_selector.sv
// Combinational round-robin pick: first eligible VC at or after the pointer, wrapping.
module tnoc_vc_rr_selector #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned VC_WIDTH = 1
) (
    input  logic [CHANNELS-1:0] i_eligible,
    input  logic [VC_WIDTH-1:0] i_pointer,
    output logic                o_found,
    output logic [VC_WIDTH-1:0] o_index
);
    logic [VC_WIDTH-1:0] w_cand [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cand
        assign w_cand[g] = VC_WIDTH'((32'(i_pointer) + g) % CHANNELS);
    end

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!o_found && i_eligible[w_cand[k]]) begin
                o_found = 1'b1;
                o_index = w_cand[k];
            end
        end
    end
endmodule

// File: rtl/tnoc_axi_vc_allocator.sv
// Dynamic VC allocator shared by the write and read requesters: per-packet VC hold,
// round-robin selection with write/read tie-break, and per-VC outstanding-packet throttling.
module tnoc_axi_vc_allocator
    import tnoc_axi_adapter_pkg::*;
#(
    parameter tnoc_config  CONFIG          = TNOC_DEFAULT_CONFIG,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tnoc_axi_vc_allocator_if.slave   vc_if
);
    localparam int unsigned CHANNELS  = CONFIG.virtual_channels;
    localparam int unsigned VC_WIDTH  = vc_width(CHANNELS);
    localparam int unsigned CNT_WIDTH = outstanding_width(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    function automatic logic [VC_WIDTH-1:0] next_vc(logic [VC_WIDTH-1:0] vc);
        return (32'(vc) == CHANNELS - 1) ? '0 : vc + 1'b1;
    endfunction

    tnoc_vc_alloc_state  r_wr_state, w_wr_state_d;
    tnoc_vc_alloc_state  r_rd_state, w_rd_state_d;
    logic [VC_WIDTH-1:0] r_wr_vc, w_wr_vc_d;
    logic [VC_WIDTH-1:0] r_rd_vc, w_rd_vc_d;
    logic [VC_WIDTH-1:0] r_ptr, w_ptr_d;
    logic                r_tie, w_tie_d;
    logic [CNT_WIDTH-1:0] r_count [CHANNELS];
    logic [CNT_WIDTH-1:0] w_count_d [CHANNELS];

    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_second_mask;
    logic                w_wr_req, w_rd_req, w_contend, w_write_first;
    logic                w_first_found, w_second_found;
    logic [VC_WIDTH-1:0] w_first_vc, w_second_vc;
    logic                w_first_alloc, w_second_alloc;
    logic                w_wr_alloc, w_rd_alloc;
    logic [VC_WIDTH-1:0] w_wr_alloc_vc, w_rd_alloc_vc;
    logic                w_wr_release, w_rd_release;

    assign w_wr_req      = (r_wr_state == IDLE) && vc_if.i_write_request;
    assign w_rd_req      = (r_rd_state == IDLE) && vc_if.i_read_request;
    assign w_contend     = w_wr_req && w_rd_req;
    // r_tie == 0 means write selects first when both contend.
    assign w_write_first = w_wr_req && (!w_rd_req || !r_tie);
    assign w_wr_release  = (r_wr_state == ALLOC) && vc_if.i_write_accept && vc_if.i_write_tail;
    assign w_rd_release  = (r_rd_state == ALLOC) && vc_if.i_read_accept && vc_if.i_read_tail;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_eligible[i] = vc_if.i_vc_available[i] && (r_count[i] < CNT_MAX)
                && !((r_wr_state == ALLOC) && (r_wr_vc == VC_WIDTH'(i)))
                && !((r_rd_state == ALLOC) && (r_rd_vc == VC_WIDTH'(i)));
        end
    end

    tnoc_vc_rr_selector #(
        .CHANNELS (CHANNELS),
        .VC_WIDTH (VC_WIDTH)
    ) u_first_sel (
        .i_eligible (w_eligible),
        .i_pointer  (r_ptr),
        .o_found    (w_first_found),
        .o_index    (w_first_vc)
    );

    always_comb begin
        w_second_mask             = w_eligible;
        w_second_mask[w_first_vc] = 1'b0;
    end

    tnoc_vc_rr_selector #(
        .CHANNELS (CHANNELS),
        .VC_WIDTH (VC_WIDTH)
    ) u_second_sel (
        .i_eligible (w_second_mask),
        .i_pointer  (next_vc(w_first_vc)),
        .o_found    (w_second_found),
        .o_index    (w_second_vc)
    );

    assign w_first_alloc  = (w_wr_req || w_rd_req) && w_first_found;
    assign w_second_alloc = w_contend && w_first_found && w_second_found;
    assign w_wr_alloc     = w_write_first ? w_first_alloc : w_second_alloc;
    assign w_rd_alloc     = w_write_first ? w_second_alloc : w_first_alloc;
    assign w_wr_alloc_vc  = w_write_first ? w_first_vc : w_second_vc;
    assign w_rd_alloc_vc  = w_write_first ? w_second_vc : w_first_vc;

    always_comb begin
        w_wr_state_d = r_wr_state;
        w_wr_vc_d    = r_wr_vc;
        unique case (r_wr_state)
            IDLE: begin
                if (w_wr_alloc) begin
                    w_wr_state_d = ALLOC;
                    w_wr_vc_d    = w_wr_alloc_vc;
                end
            end
            ALLOC: begin
                if (w_wr_release) w_wr_state_d = IDLE;
            end
            default: w_wr_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_d = r_rd_state;
        w_rd_vc_d    = r_rd_vc;
        unique case (r_rd_state)
            IDLE: begin
                if (w_rd_alloc) begin
                    w_rd_state_d = ALLOC;
                    w_rd_vc_d    = w_rd_alloc_vc;
                end
            end
            ALLOC: begin
                if (w_rd_release) w_rd_state_d = IDLE;
            end
            default: w_rd_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_ptr_d = r_ptr;
        w_tie_d = r_tie;
        if (w_second_alloc) begin
            w_ptr_d = next_vc(w_second_vc);
        end else if (w_first_alloc) begin
            w_ptr_d = next_vc(w_first_vc);
        end
        if (w_contend && w_first_alloc) w_tie_d = !r_tie;
    end

    // Same-cycle allocate and complete on one VC cancel; completion at zero is dropped.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            logic inc;
            logic dec;
            inc = (w_wr_alloc && (w_wr_alloc_vc == VC_WIDTH'(i)))
                || (w_rd_alloc && (w_rd_alloc_vc == VC_WIDTH'(i)));
            dec = vc_if.i_done_valid && (vc_if.i_done_vc == VC_WIDTH'(i)) && (r_count[i] != '0);
            w_count_d[i] = r_count[i];
            if (inc && !dec) begin
                w_count_d[i] = r_count[i] + 1'b1;
            end else if (dec && !inc) begin
                w_count_d[i] = r_count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= IDLE;
            r_rd_state <= IDLE;
            r_wr_vc    <= '0;
            r_rd_vc    <= '0;
            r_ptr      <= '0;
            r_tie      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) r_count[i] <= '0;
        end else begin
            r_wr_state <= w_wr_state_d;
            r_rd_state <= w_rd_state_d;
            r_wr_vc    <= w_wr_vc_d;
            r_rd_vc    <= w_rd_vc_d;
            r_ptr      <= w_ptr_d;
            r_tie      <= w_tie_d;
            for (int i = 0; i < CHANNELS; i++) r_count[i] <= w_count_d[i];
        end
    end

    assign vc_if.o_write_grant = (r_wr_state == ALLOC);
    assign vc_if.o_write_vc    = r_wr_vc;
    assign vc_if.o_read_grant  = (r_rd_state == ALLOC);
    assign vc_if.o_read_vc     = r_rd_vc;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(vc_if.i_write_accept && (r_wr_state == IDLE)))
                else $error("write accept without an allocated VC");
            assert (!(vc_if.i_read_accept && (r_rd_state == IDLE)))
                else $error("read accept without an allocated VC");
            assert (!(vc_if.i_done_valid && (r_count[vc_if.i_done_vc] == '0)))
                else $warning("completion on VC %0d with no outstanding packet ignored",
                              vc_if.i_done_vc);
        end
    end
endmodule

// File: tb/tb_tnoc_axi_vc_allocator.sv
// Scoreboarded bench: directed scenarios plus random traffic against a packet-level VC model.
module tb_tnoc_axi_vc_allocator;
    import tnoc_axi_adapter_pkg::*;

    localparam int C    = 2;
    localparam int MAXO = 2;
    localparam int VW   = 1;
    localparam tnoc_config TB_CFG = '{virtual_channels: 2};

    typedef struct packed {
        logic          wg;
        logic [VW-1:0] wv;
        logic          rg;
        logic [VW-1:0] rv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tnoc_axi_vc_allocator_if #(.CHANNELS(C), .VC_WIDTH(VW)) vif ();

    tnoc_axi_vc_allocator #(
        .CONFIG          (TB_CFG),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vc_if (vif.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference state: which requester holds which VC, packets in flight per VC,
    // the shared round-robin start and whose turn it is to choose first.
    bit m_wbusy, m_rbusy, m_tie;
    int m_wvc, m_rvc, m_ptr;
    int m_cnt [C];

    function automatic void model_reset();
        m_wbusy = 0; m_rbusy = 0; m_tie = 0;
        m_wvc = 0; m_rvc = 0; m_ptr = 0;
        for (int i = 0; i < C; i++) m_cnt[i] = 0;
    endfunction

    function automatic int pick(logic [C-1:0] av, int excl);
        for (int k = 0; k < C; k++) begin
            int v;
            v = (m_ptr + k) % C;
            if (v != excl && av[v] && m_cnt[v] < MAXO && !(m_wbusy && m_wvc == v)
                && !(m_rbusy && m_rvc == v)) return v;
        end
        return -1;
    endfunction

    function automatic void model_cycle(logic [C-1:0] av, bit wreq, bit wacc, bit wtail,
                                        bit rreq, bit racc, bit rtail, bit dv, int dvc);
        bit wi, ri, wfirst, dec;
        int first, second, wpick, rpick;
        wi = !m_wbusy && wreq;
        ri = !m_rbusy && rreq;
        wfirst = (wi && ri) ? !m_tie : wi;
        first = -1; second = -1;
        if (wi || ri) first = pick(av, -1);
        if (wi && ri && first >= 0) second = pick(av, first);
        wpick = -1; rpick = -1;
        if (wi) wpick = wfirst ? first : second;
        if (ri) rpick = wfirst ? second : first;
        if (second >= 0) m_ptr = (second + 1) % C;
        else if (first >= 0) m_ptr = (first + 1) % C;
        if (wi && ri && first >= 0) m_tie = !m_tie;
        dec = dv && m_cnt[dvc] > 0;
        if (wpick >= 0) m_cnt[wpick]++;
        if (rpick >= 0) m_cnt[rpick]++;
        if (dec) m_cnt[dvc]--;
        if (m_wbusy && wacc && wtail) m_wbusy = 0;
        if (m_rbusy && racc && rtail) m_rbusy = 0;
        if (wpick >= 0) begin m_wbusy = 1; m_wvc = wpick; end
        if (rpick >= 0) begin m_rbusy = 1; m_rvc = rpick; end
    endfunction

    task automatic step(input logic [C-1:0] av, input bit wreq, input bit wacc, input bit wtail,
                        input bit rreq, input bit racc, input bit rtail,
                        input bit dv, input int dvc);
        exp_t e;
        @(negedge clk);
        vif.i_vc_available  = av;
        vif.i_write_request = wreq;
        vif.i_write_accept  = wacc;
        vif.i_write_tail    = wtail;
        vif.i_read_request  = rreq;
        vif.i_read_accept   = racc;
        vif.i_read_tail     = rtail;
        vif.i_done_valid    = dv;
        vif.i_done_vc       = VW'(dvc);
        model_cycle(av, wreq, wacc, wtail, rreq, racc, rtail, dv, dvc);
        e.wg = m_wbusy; e.wv = VW'(m_wvc);
        e.rg = m_rbusy; e.rv = VW'(m_rvc);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input bit wg, input int wv, input bit rg,
                             input int rv);
        checks++;
        if (vif.o_write_grant !== wg || vif.o_write_vc !== VW'(wv)
            || vif.o_read_grant !== rg || vif.o_read_vc !== VW'(rv)) begin
            errors++;
            $display("FAIL %s: got wg=%0b wvc=%0d rg=%0b rvc=%0d, want wg=%0b wvc=%0d rg=%0b rvc=%0d",
                     name, vif.o_write_grant, vif.o_write_vc, vif.o_read_grant, vif.o_read_vc,
                     wg, wv, rg, rv);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_out("async reset", 0, 0, 0, 0);
        q.delete();
        model_reset();
        vif.i_vc_available  = '0;
        vif.i_write_request = 0; vif.i_write_accept = 0; vif.i_write_tail = 0;
        vif.i_read_request  = 0; vif.i_read_accept  = 0; vif.i_read_tail  = 0;
        vif.i_done_valid    = 0; vif.i_done_vc      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (vif.o_write_grant !== e.wg || vif.o_write_vc !== e.wv
                || vif.o_read_grant !== e.rg || vif.o_read_vc !== e.rv) begin
                errors++;
                $display("FAIL scoreboard @%0t: got wg=%0b wvc=%0d rg=%0b rvc=%0d, want wg=%0b wvc=%0d rg=%0b rvc=%0d",
                         $time, vif.o_write_grant, vif.o_write_vc, vif.o_read_grant,
                         vif.o_read_vc, e.wg, e.wv, e.rg, e.rv);
            end
        end
    end

    initial begin
        do_reset();

        // Single write, three flits.
        step(2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("first write alloc", 1, 0, 0, 0);
        step(2'b11, 1, 1, 0, 0, 0, 0, 0, 0);
        step(2'b11, 1, 1, 0, 0, 0, 0, 0, 0);
        step(2'b11, 0, 1, 1, 0, 0, 0, 0, 0);
        check_out("write tail release", 0, 0, 0, 0);

        // Contended allocation, tie-break alternates.
        do_reset();
        step(2'b11, 1, 0, 0, 1, 0, 0, 0, 0);
        check_out("dual alloc write first", 1, 0, 1, 1);
        step(2'b11, 0, 1, 1, 0, 1, 1, 0, 0);
        step(2'b11, 1, 0, 0, 1, 0, 0, 0, 0);
        check_out("dual alloc read first", 1, 1, 1, 0);
        step(2'b11, 0, 1, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(2'b11, 0, 0, 0, 0, 0, 0, 1, i % 2);

        // One VC available: loser waits for the winner's tail.
        step(2'b10, 1, 0, 0, 1, 0, 0, 0, 0);
        check_out("single vc winner", 1, 1, 0, 0);
        step(2'b10, 0, 1, 1, 1, 0, 0, 0, 0);
        check_out("loser blocked on tail cycle", 0, 1, 0, 0);
        step(2'b10, 0, 0, 0, 1, 0, 0, 0, 0);
        check_out("loser granted after tail", 0, 1, 1, 1);
        step(2'b10, 0, 0, 0, 0, 1, 1, 0, 0);

        // Outstanding limit on vc0.
        do_reset();
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        step(2'b01, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("second packet vc0", 1, 0, 0, 0);
        step(2'b01, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("stall at limit", 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 1, 0);
        check_out("stall during done", 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("grant after done", 1, 0, 0, 0);
        step(2'b01, 0, 1, 1, 0, 0, 0, 0, 0);

        // Done coincident with allocation keeps the count.
        step(2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 1, 0);
        check_out("alloc with done", 1, 0, 0, 0);
        step(2'b01, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("count held at one", 1, 0, 0, 0);
        step(2'b01, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("limit after coincident", 0, 0, 0, 0);

        // Done on an idle VC must not underflow.
        do_reset();
        step(2'b11, 0, 0, 0, 0, 0, 0, 1, 1);
        step(2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
        step(2'b10, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("no underflow second", 1, 1, 0, 0);
        step(2'b10, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("no underflow limit", 0, 1, 0, 0);

        // Reset while a write holds a VC.
        do_reset();
        step(2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        step(2'b11, 1, 1, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
        check_out("restart at vc0", 1, 0, 0, 0);
        step(2'b11, 0, 1, 1, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [C-1:0] av;
            bit wreq, wacc, wtail, rreq, racc, rtail, dv;
            int dvc;
            av    = C'($urandom_range(0, (1 << C) - 1));
            wreq  = ($urandom_range(0, 9) < 6);
            rreq  = ($urandom_range(0, 9) < 6);
            wacc  = m_wbusy && ($urandom_range(0, 3) != 0);
            racc  = m_rbusy && ($urandom_range(0, 3) != 0);
            wtail = wacc && ($urandom_range(0, 2) == 0);
            rtail = racc && ($urandom_range(0, 2) == 0);
            dvc   = $urandom_range(0, C - 1);
            dv    = (m_cnt[dvc] > 0) && ($urandom_range(0, 2) == 0);
            step(av, wreq, wacc, wtail, rreq, racc, rtail, dv, dvc);
        end

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
